// File: rtl/mux41_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux41_rr_arbiter_pkg
// Shared definitions for the 4:1 mux round-robin arbiter:
//   - N_CH / SEL_W : channel count and select width
//   - state_e      : arbiter FSM states (IDLE, GRANT, GAP)
// -----------------------------------------------------------------------------
package mux41_rr_arbiter_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux41_rr_arbiter_if
// Bundle between the requesters and the arbiter.
//   req  [3:0] level request per channel      (requester -> arbiter)
//   din  [3:0] data bit per channel           (requester -> arbiter)
//   gnt  [3:0] one-hot grant, 0 when idle     (arbiter -> requester)
//   sel  [1:0] mux select, holds when idle    (arbiter -> consumer)
//   busy       high whenever gnt != 0         (arbiter -> consumer)
//   dout       registered din[sel] while busy (arbiter -> consumer)
// master = requester/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mux41_rr_arbiter_if;
  import mux41_rr_arbiter_pkg::*;

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  din;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             dout;

  modport master (output req, din, input gnt, sel, busy, dout);
  modport slave  (input req, din, output gnt, sel, busy, dout);

endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotating-priority picker.
//   req_i [3:0] requests
//   ptr_i [1:0] favoured channel (scanned first)
//   any_o       at least one request
//   idx_o [1:0] first requesting channel scanning ptr, ptr+1, ... modulo 4
// Rotate the request vector so ptr lands on bit 0, take the lowest set bit,
// then add ptr back (2-bit wrap undoes the rotation).
// -----------------------------------------------------------------------------
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    off = '0;
    rot = N_CH'({req_i, req_i} >> ptr_i);
    // Descending scan so the lowest set bit wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    any_o = |req_i;
    idx_o = ptr_i + off;
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux41_rr_arbiter
// Round-robin arbiter/sequencer for the shared 4:1 single-bit mux path.
// Grants one requester at a time, limits a grant to SLOT_LEN cycles while
// others wait, inserts one idle cycle between grants and registers the
// selected data bit.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  mux41_rr_arbiter_if.slave (req, din in; gnt, sel, busy, dout out)
// Parameters:
//   SLOT_LEN  max grant length while another request is pending (>= 2)
//   CNT_W     slot counter width, 2**CNT_W >= SLOT_LEN
// -----------------------------------------------------------------------------
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int SLOT_LEN = 8,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mux41_rr_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_LEN - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N_CH-1:0]  gnt_q,   gnt_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             dout_q,  dout_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             release_c;
  logic             expire_c;

  rr_pick4 u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Owner dropped its request, or the slot ran out while someone else waits.
  // With no other requester the saturated owner simply keeps the path.
  assign release_c = ~bus.req[sel_q];
  assign expire_c  = (cnt_q == CNT_MAX) && (|(bus.req & ~gnt_q));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = N_CH'(1) << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_c || expire_c) begin
          // Favour the channel after the owner so it cannot win back-to-back
          // while others are waiting.
          state_d = ST_GAP;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    dout_d = (state_d == ST_GRANT) ? bus.din[sel_d] : 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = |gnt_q;
  assign bus.dout = dout_q;

endmodule
